// File: rtl/pdu_mb_if.sv
// pdu_mb_if: CPU memory-mapped I/O and debug-read bus between the CPU (master) and pdu_mb (slave)
interface pdu_mb_if;
  logic [7:0] io_addr;
  logic [31:0] io_dout;
  logic io_we;
  logic io_rd;
  logic [31:0] io_din;
  logic [7:0] dm_rf_addr;
  logic [31:0] rf_data;
  logic [31:0] dm_data;
  logic [31:0] pc;
  modport master(
    output io_addr, io_dout, io_we, io_rd, rf_data, dm_data, pc,
    input io_din, dm_rf_addr
  );
  modport slave(
    input io_addr, io_dout, io_we, io_rd, rf_data, dm_data, pc,
    output io_din, dm_rf_addr
  );
endinterface

// File: rtl/pdu_mb.sv
// pdu_mb: program debug unit - CPU run control, breakpoints, polled key FIFO, MMIO decode and display select
module pdu_mb #(
  parameter int NUM_BRK = 4,
  parameter int IN_DEPTH = 8,
  parameter int CNT_W = 16,
  parameter logic [7:0] IO_LED = 8'h00,
  parameter logic [7:0] IO_SW = 8'h04,
  parameter logic [7:0] IO_POL_OUT = 8'h08,
  parameter logic [7:0] IO_POL_OUT_VLD = 8'h0C,
  parameter logic [7:0] IO_POL_IN = 8'h10,
  parameter logic [7:0] IO_POL_IN_VLD = 8'h14,
  parameter logic [7:0] IO_STAT = 8'h18
) (
  input logic clk,
  input logic rst,
  input logic step,
  input logic cont,
  input logic run_n,
  input logic chk,
  input logic ent,
  input logic brk_set,
  input logic brk_clr,
  input logic key_evt,
  input logic [31:0] key_data,
  input logic [15:0] hd,
  output logic cpu_en,
  output logic pause,
  output logic [15:0] led,
  output logic [31:0] disp_data,
  pdu_mb_if.slave bus
);
  localparam int BW = $clog2(NUM_BRK);
  localparam int AW = $clog2(IN_DEPTH);
  localparam logic [1:0] PAUSE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] CONT = 2'd2;
  localparam logic [1:0] RUNN = 2'd3;
  localparam logic [1:0] SEL_KEY = 2'd0;
  localparam logic [1:0] SEL_PC = 2'd1;
  localparam logic [1:0] SEL_RF = 2'd2;
  localparam logic [1:0] SEL_DM = 2'd3;

  logic [1:0] mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic skip_q, skip_d;
  logic [31:0] brk_q [NUM_BRK];
  logic [NUM_BRK-1:0] en_q;
  logic [1:0] sel_q;
  logic [31:0] fifo_q [IN_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  logic ovf_q;
  logic out_vld_q;
  logic [31:0] out_q;
  logic [15:0] led_q;
  logic [NUM_BRK-1:0] match;
  logic hit, run_cyc, paused, empty, full, push, pop, push_ok, stat_rd;
  logic [CNT_W-1:0] n_req;
  logic [31:0] stat;

  for (genvar i = 0; i < NUM_BRK; i++) begin : g_match
    assign match[i] = en_q[i] & (brk_q[i] == bus.pc);
  end

  assign hit = !skip_q & |match;
  assign paused = mode_q == PAUSE;
  // CONT and RUNN share bit 1; a hit suppresses the breakpointed instruction
  assign run_cyc = (mode_q == STEP) | (mode_q[1] & !hit);
  assign cpu_en = run_cyc & !rst;
  assign pause = paused;
  assign n_req = key_data[CNT_W-1:0];

  always_comb begin
    mode_d = mode_q;
    cnt_d = cnt_q;
    skip_d = run_cyc ? 1'b0 : skip_q;
    if (paused) begin
      if (step) begin
        mode_d = STEP;
        skip_d = 1'b1;
      end else if (run_n) begin
        if (n_req != '0) begin
          mode_d = RUNN;
          cnt_d = n_req;
          skip_d = 1'b1;
        end
      end else if (cont) begin
        mode_d = CONT;
        skip_d = 1'b1;
      end
    end else if (mode_q == STEP || hit) begin
      mode_d = PAUSE;
    end else if (mode_q == RUNN) begin
      cnt_d = cnt_q - CNT_W'(1);
      mode_d = cnt_q == CNT_W'(1) ? PAUSE : RUNN;
    end
  end

  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(IN_DEPTH);
  assign push = ent & !paused;
  assign pop = bus.io_rd & (bus.io_addr == IO_POL_IN) & !empty;
  assign push_ok = push & (!full | pop);
  assign stat_rd = bus.io_rd & (bus.io_addr == IO_STAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= PAUSE;
      cnt_q <= '0;
      skip_q <= 1'b0;
      en_q <= '0;
      for (int k = 0; k < NUM_BRK; k++) brk_q[k] <= '1;
      sel_q <= SEL_KEY;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q <= '0;
      led_q <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      skip_q <= skip_d;
      if (paused & brk_clr) begin
        en_q <= '0;
      end else if (paused & brk_set) begin
        brk_q[hd[BW-1:0]] <= key_data;
        en_q[hd[BW-1:0]] <= 1'b1;
      end
      if (paused & chk) sel_q <= key_data[15:14] == 2'b00 ? key_data[13:12] : SEL_KEY;
      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      ovf_q <= (push & !push_ok) | (ovf_q & !stat_rd);
      if (bus.io_we && bus.io_addr == IO_POL_OUT) begin
        out_q <= bus.io_dout;
        out_vld_q <= 1'b1;
      end else if (key_evt) begin
        out_vld_q <= 1'b0;
      end
      if (bus.io_we && bus.io_addr == IO_LED) led_q <= bus.io_dout[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wp_q] <= key_data;
  end

  assign led = paused ? key_data[15:0] : led_q;
  assign bus.dm_rf_addr = key_data[7:0];
  assign disp_data = sel_q == SEL_PC ? bus.pc :
                     sel_q == SEL_RF ? bus.rf_data :
                     sel_q == SEL_DM ? bus.dm_data :
                     (out_vld_q && bus.io_addr == IO_POL_OUT) ? out_q : key_data;
  assign stat = 32'({count_q, ovf_q, mode_q});
  assign bus.io_din = bus.io_addr == IO_SW ? {16'b0, hd} :
                      bus.io_addr == IO_POL_IN ? (empty ? '0 : fifo_q[rp_q]) :
                      bus.io_addr == IO_POL_IN_VLD ? {31'b0, !empty} :
                      bus.io_addr == IO_POL_OUT_VLD ? {31'b0, out_vld_q} :
                      bus.io_addr == IO_STAT ? stat : '0;
endmodule

// File: tb/tb_pdu_mb.sv
// tb_pdu_mb: directed bench for pdu_mb with a queue-based reference model checked every cycle
module tb_pdu_mb;
  typedef enum int {M_PAUSE = 0, M_STEP = 1, M_CONT = 2, M_RUNN = 3} mode_t;

  logic clk = 0, rst = 1;
  logic step = 0, cont = 0, run_n = 0, chk = 0, ent = 0, brk_set = 0, brk_clr = 0, key_evt = 0;
  logic [31:0] key_data = 32'h0000_1234;
  logic [15:0] hd = 16'h0;
  logic cpu_en, pause;
  logic [15:0] led;
  logic [31:0] disp_data;
  logic [31:0] pc_r = 0;
  logic pc_run = 0;
  int n_chk = 0, n_err = 0;

  pdu_mb_if bus();
  assign bus.pc = pc_r;
  assign bus.rf_data = 32'hAAAA_5555;
  assign bus.dm_data = 32'h0D0D_F00D;

  pdu_mb dut (
    .clk(clk), .rst(rst), .step(step), .cont(cont), .run_n(run_n), .chk(chk), .ent(ent),
    .brk_set(brk_set), .brk_clr(brk_clr), .key_evt(key_evt), .key_data(key_data), .hd(hd),
    .cpu_en(cpu_en), .pause(pause), .led(led), .disp_data(disp_data), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // a trivial CPU: each enabled cycle retires one instruction
  always @(posedge clk) if (pc_run && cpu_en) pc_r <= pc_r + 4;

  mode_t m_mode;
  int m_cnt, m_sel;
  bit m_skip, m_ovf, m_vld;
  logic [31:0] m_brk [4];
  bit m_en [4];
  logic [31:0] m_out;
  logic [15:0] m_led;
  logic [31:0] q [$];

  function automatic void m_reset();
    m_mode = M_PAUSE; m_cnt = 0; m_sel = 0; m_skip = 0; m_ovf = 0; m_vld = 0;
    m_out = 0; m_led = 0; q.delete();
    for (int i = 0; i < 4; i++) begin m_brk[i] = '1; m_en[i] = 0; end
  endfunction

  function automatic bit m_hit();
    bit h = 0;
    for (int i = 0; i < 4; i++) if (m_en[i] && m_brk[i] == pc_r) h = 1;
    return h && !m_skip;
  endfunction

  function automatic bit m_exec();
    return m_mode == M_STEP || ((m_mode == M_CONT || m_mode == M_RUNN) && !m_hit());
  endfunction

  function automatic void m_step();
    bit p = m_mode == M_PAUSE;
    bit h = m_hit();
    bit drop = 0;
    bit stat = bus.io_rd && bus.io_addr == 8'h18;
    if (m_exec()) m_skip = 0;
    if (p) begin
      if (step) begin m_mode = M_STEP; m_skip = 1; end
      else if (run_n) begin
        if (key_data[15:0] != 0) begin m_mode = M_RUNN; m_cnt = int'(key_data[15:0]); m_skip = 1; end
      end else if (cont) begin m_mode = M_CONT; m_skip = 1; end
      if (brk_clr) for (int i = 0; i < 4; i++) m_en[i] = 0;
      else if (brk_set) begin m_brk[hd[1:0]] = key_data; m_en[hd[1:0]] = 1; end
      if (chk) m_sel = key_data[15:12] inside {[4'd1:4'd3]} ? int'(key_data[15:12]) : 0;
    end else if (m_mode == M_STEP || h) m_mode = M_PAUSE;
    else if (m_mode == M_RUNN) begin
      m_cnt--;
      if (m_cnt == 0) m_mode = M_PAUSE;
    end
    if (bus.io_rd && bus.io_addr == 8'h10 && q.size() > 0) void'(q.pop_front());
    if (ent && !p) begin
      if (q.size() < 8) q.push_back(key_data); else drop = 1;
    end
    m_ovf = drop || (m_ovf && !stat);
    if (bus.io_we && bus.io_addr == 8'h08) begin m_out = bus.io_dout; m_vld = 1; end
    else if (key_evt) m_vld = 0;
    if (bus.io_we && bus.io_addr == 8'h00) m_led = bus.io_dout[15:0];
  endfunction

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) if (rst) m_reset(); else m_step();

  always @(negedge clk) begin
    logic [31:0] e_disp, e_din;
    if (rst) m_reset();
    e_disp = m_sel == 1 ? pc_r : m_sel == 2 ? bus.rf_data : m_sel == 3 ? bus.dm_data :
             (m_vld && bus.io_addr == 8'h08) ? m_out : key_data;
    case (bus.io_addr)
      8'h04: e_din = {16'b0, hd};
      8'h10: e_din = q.size() > 0 ? q[0] : 32'h0;
      8'h14: e_din = 32'(q.size() > 0);
      8'h0C: e_din = 32'(m_vld);
      8'h18: e_din = 32'(q.size() * 8 + int'(m_ovf) * 4 + int'(m_mode));
      default: e_din = 32'h0;
    endcase
    check("m_cpu_en", 32'(cpu_en), 32'(!rst && m_exec()));
    check("m_pause", 32'(pause), 32'(m_mode == M_PAUSE));
    check("m_led", 32'(led), 32'(m_mode == M_PAUSE ? key_data[15:0] : m_led));
    check("m_disp", disp_data, e_disp);
    check("m_io_din", bus.io_din, e_din);
    check("m_dm_rf_addr", 32'(bus.dm_rf_addr), 32'(key_data[7:0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    step = 0; cont = 0; run_n = 0; chk = 0; ent = 0; brk_set = 0; brk_clr = 0; key_evt = 0;
    bus.io_we = 0; bus.io_rd = 0;
  endtask

  initial begin
    int n;
    logic [31:0] far_pc;
    bus.io_addr = 8'h18; bus.io_dout = 0; bus.io_we = 0; bus.io_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_pause", 32'(pause), 1);
    check("rst_led", 32'(led), 32'h1234);
    check("rst_disp", disp_data, 32'h1234);
    check("rst_stat", bus.io_din, 0);
    tick(); step = 1; tick();
    @(negedge clk);
    check("step_en", 32'(cpu_en), 1);
    check("step_pause", 32'(pause), 0);
    tick();
    @(negedge clk);
    check("step_done_en", 32'(cpu_en), 0);
    check("step_done_pause", 32'(pause), 1);
    tick(); hd = 1; key_data = 32'h10; brk_set = 1;
    tick(); hd = 2; key_data = 32'h20; brk_set = 1;
    tick(); key_data = 32'h1234; pc_run = 1; cont = 1;
    tick();
    n = 0;
    while (pc_r != 32'h10 && n < 20) begin @(negedge clk); n++; end
    check("bp_reach", pc_r, 32'h10);
    check("bp_gate", 32'(cpu_en), 0);
    tick();
    @(negedge clk);
    check("bp_paused", 32'(pause), 1);
    check("bp_pc_hold", pc_r, 32'h10);
    tick(); cont = 1; tick();
    @(negedge clk);
    check("resume_en", 32'(cpu_en), 1);
    tick();
    @(negedge clk);
    check("resume_pc", pc_r, 32'h14);
    check("resume_en2", 32'(cpu_en), 1);
    n = 0;
    while (!pause && n < 20) begin @(negedge clk); n++; end
    check("bp2_pc", pc_r, 32'h20);
    tick(); key_data = 32'h0000_1000; chk = 1; tick();
    @(negedge clk);
    check("disp_pc", disp_data, 32'h20);
    check("led_pause", 32'(led), 32'h1000);
    tick(); key_data = 32'h0000_2000; chk = 1; tick();
    @(negedge clk);
    check("disp_rf", disp_data, 32'hAAAA_5555);
    tick(); key_data = 32'h0000_30AB; chk = 1; tick();
    @(negedge clk);
    check("disp_dm", disp_data, 32'h0D0D_F00D);
    check("dm_rf_addr", 32'(bus.dm_rf_addr), 32'hAB);
    tick(); key_data = 32'h0000_0003; chk = 1; tick();
    @(negedge clk);
    check("disp_key", disp_data, 32'h3);
    tick(); brk_clr = 1; run_n = 1; tick();
    n = 0;
    repeat (8) begin @(negedge clk); if (cpu_en) n++; end
    check("runn3_count", n, 3);
    check("runn3_pause", 32'(pause), 1);
    tick(); key_data = 0; run_n = 1; tick();
    n = 0;
    repeat (5) begin @(negedge clk); if (cpu_en) n++; end
    check("runn0_count", n, 0);
    check("runn0_pause", 32'(pause), 1);
    tick(); far_pc = pc_r + 32'h400; hd = 3; key_data = far_pc; brk_set = 1;
    tick(); cont = 1;
    tick();
    for (int i = 1; i <= 9; i++) begin key_data = i; ent = 1; tick(); end
    bus.io_addr = 8'h14; bus.io_rd = 1;
    @(negedge clk);
    check("fifo_vld", bus.io_din, 1);
    tick(); bus.io_addr = 8'h18; bus.io_rd = 1;
    @(negedge clk);
    check("fifo_stat_full", bus.io_din, 32'h46);
    tick();
    for (int i = 1; i <= 8; i++) begin
      bus.io_addr = 8'h10; bus.io_rd = 1;
      @(negedge clk);
      check("fifo_pop", bus.io_din, i);
      tick();
    end
    bus.io_addr = 8'h14; bus.io_rd = 1;
    @(negedge clk);
    check("fifo_empty", bus.io_din, 0);
    tick(); bus.io_addr = 8'h18; bus.io_rd = 1;
    @(negedge clk);
    check("stat_ovf_clr", bus.io_din, 32'h02);
    tick(); bus.io_addr = 8'h00; bus.io_dout = 32'hBEEF_5A5A; bus.io_we = 1;
    tick();
    @(negedge clk);
    check("led_reg", 32'(led), 32'h5A5A);
    tick(); bus.io_addr = 8'h08; bus.io_dout = 32'hDEAD_BEEF; bus.io_we = 1;
    tick();
    @(negedge clk);
    check("out_disp", disp_data, 32'hDEAD_BEEF);
    tick(); bus.io_addr = 8'h0C; bus.io_rd = 1;
    @(negedge clk);
    check("out_vld", bus.io_din, 1);
    tick(); bus.io_addr = 8'h08; key_evt = 1; key_data = 32'h5555_0000;
    tick();
    @(negedge clk);
    check("out_cleared_disp", disp_data, 32'h5555_0000);
    tick(); key_data = 7; ent = 1;
    tick(); ent = 1;
    tick(); bus.io_addr = 8'h14; rst = 1;
    @(negedge clk);
    check("rst_mid_en", 32'(cpu_en), 0);
    check("rst_mid_pause", 32'(pause), 1);
    check("rst_mid_fifo", bus.io_din, 0);
    tick(); rst = 0;
    tick(); cont = 1;
    tick();
    n = 0;
    while (pc_r != far_pc && n < 400) begin @(negedge clk); n++; end
    check("rst_brk_reach", pc_r, far_pc);
    check("rst_brk_cleared", 32'(cpu_en), 1);
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
